// File: rtl/hw_frame_pkg.sv
// hw_frame_latch shared types: FSM states, latched op, command/status codes.
// Default geometry: 13 PIO words of 32 bits, 16-bit swap counter.
package hw_frame_pkg;

    localparam int DEF_NUM_PORTS = 13;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_CNT_W     = 16;

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_COMMIT = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b10;
    localparam logic [1:0] CMD_RSVD   = 2'b11;

    localparam logic [1:0] STS_READY = 2'b00;
    localparam logic [1:0] STS_ACK   = 2'b01;
    localparam logic [1:0] STS_BUSY  = 2'b10;
    localparam logic [1:0] STS_ERROR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_WAIT_FRAME,
        ST_ACK,
        ST_ERR
    } state_t;

    typedef enum logic {
        OP_COMMIT,
        OP_CLEAR
    } op_t;

    function automatic logic [1:0] status_of(state_t s);
        logic [1:0] r;
        r = STS_READY;
        case (s)
            ST_CAPTURE:    r = STS_BUSY;
            ST_WAIT_FRAME: r = STS_BUSY;
            ST_ACK:        r = STS_ACK;
            ST_ERR:        r = STS_ERROR;
            default:       r = STS_READY;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/frame_reg_bank.sv
// Shadow + active word banks. Shadow word wr_idx_i loads from data_i on
// wr_en_i; swap_i copies shadow to active, clear_i zeroes active. Out: active_o.
module frame_reg_bank #(
    parameter int NUM_PORTS = 13,
    parameter int WIDTH     = 32,
    parameter int IDX_W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [IDX_W-1:0]           wr_idx_i,
    input  logic [NUM_PORTS*WIDTH-1:0] data_i,
    input  logic                       swap_i,
    input  logic                       clear_i,
    output logic [NUM_PORTS*WIDTH-1:0] active_o
);

    logic [NUM_PORTS*WIDTH-1:0] shadow_q;
    logic [NUM_PORTS*WIDTH-1:0] active_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (wr_en_i && wr_idx_i == IDX_W'(k)) begin
                    shadow_q[k*WIDTH +: WIDTH] <= data_i[k*WIDTH +: WIDTH];
                end
            end
            if (clear_i) begin
                active_q <= '0;
            end else if (swap_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/hw_frame_latch.sv
// Tear-free frame parameter latch behind the nios PIO exports.
// In: port_data, hw_sig, frame_start. Out: sw_sig, frame_data/valid/count.
module hw_frame_latch
    import hw_frame_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [NUM_PORTS*WIDTH-1:0] port_data,
    input  logic [1:0]                 hw_sig,
    input  logic                       frame_start,
    output logic [1:0]                 sw_sig,
    output logic [NUM_PORTS*WIDTH-1:0] frame_data,
    output logic                       frame_valid,
    output logic [CNT_W-1:0]           frame_count
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PORTS - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [1:0]       cmd_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       sw_q, sw_d;
    logic             wr_en, swap, clr;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wr_en   = 1'b0;
        swap    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (cmd_q)
                    CMD_COMMIT: begin
                        idx_d   = '0;
                        op_d    = OP_COMMIT;
                        state_d = ST_CAPTURE;
                    end
                    CMD_CLEAR: begin
                        op_d    = OP_CLEAR;
                        state_d = ST_WAIT_FRAME;
                    end
                    CMD_RSVD: state_d = ST_ERR;
                    default:  state_d = ST_IDLE;
                endcase
            end
            ST_CAPTURE: begin
                // Abort wins over the capture of the current word.
                if (cmd_q == CMD_IDLE) begin
                    state_d = ST_IDLE;
                end else begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                if (cmd_q == CMD_IDLE) begin
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    swap    = (op_q == OP_COMMIT);
                    clr     = (op_q == OP_CLEAR);
                    valid_d = (op_q == OP_COMMIT);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK, ST_ERR: begin
                if (cmd_q == CMD_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status is registered from the next state so it moves on the
        // same edge as the state it reports.
        sw_d = status_of(state_d);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_COMMIT;
            cmd_q   <= CMD_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sw_q    <= STS_READY;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cmd_q   <= hw_sig;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sw_q    <= sw_d;
        end
    end

    frame_reg_bank #(
        .NUM_PORTS(NUM_PORTS),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .wr_en_i (wr_en),
        .wr_idx_i(idx_q),
        .data_i  (port_data),
        .swap_i  (swap),
        .clear_i (clr),
        .active_o(frame_data)
    );

    assign sw_sig      = sw_q;
    assign frame_valid = valid_q;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_hw_frame_latch.sv
// Bench for hw_frame_latch: directed scenarios plus random command traffic
// checked each cycle against a word-level reference model.
module tb_hw_frame_latch;

    localparam int NP = 13;
    localparam int W  = 32;
    localparam int CW = 16;
    localparam int NW = NP * W;

    localparam int MP_IDLE = 0;
    localparam int MP_CAP  = 1;
    localparam int MP_WAIT = 2;
    localparam int MP_ACK  = 3;
    localparam int MP_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NW-1:0] port_data = '0;
    logic [1:0]    hw_sig = 2'b00;
    logic          frame_start = 1'b0;
    logic [1:0]    sw_sig;
    logic [NW-1:0] frame_data;
    logic          frame_valid;
    logic [CW-1:0] frame_count;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    logic [1:0]    m_cmd, m_c;
    int            m_phase, m_taken;
    bit            m_clear, m_valid;
    logic [W-1:0]  m_shadow[NP];
    logic [W-1:0]  m_active[NP];
    logic [CW-1:0] m_count;
    logic [NW-1:0] m_exp;

    hw_frame_latch dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .port_data    (port_data),
        .hw_sig       (hw_sig),
        .frame_start  (frame_start),
        .sw_sig       (sw_sig),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] m_status(int p);
        if (p == MP_CAP || p == MP_WAIT) return 2'b10;
        if (p == MP_ACK) return 2'b01;
        if (p == MP_ERR) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [NW-1:0] act,
                         input logic [NW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: words are copied one per cycle while a commit is being
    // gathered; the active bank only ever changes at a frame pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd = 2'b00;
            m_phase = MP_IDLE;
            m_taken = 0;
            m_clear = 1'b0;
            m_valid = 1'b0;
            m_count = '0;
            for (int k = 0; k < NP; k++) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
            end
        end else begin
            m_c = m_cmd;
            m_cmd = hw_sig;
            case (m_phase)
                MP_IDLE: begin
                    if (m_c == 2'b01) begin
                        m_clear = 1'b0;
                        m_taken = 0;
                        m_phase = MP_CAP;
                    end else if (m_c == 2'b10) begin
                        m_clear = 1'b1;
                        m_phase = MP_WAIT;
                    end else if (m_c == 2'b11) begin
                        m_phase = MP_ERR;
                    end
                end
                MP_CAP: begin
                    if (m_c == 2'b00) begin
                        m_phase = MP_IDLE;
                    end else begin
                        m_shadow[m_taken] = port_data[m_taken*W +: W];
                        m_taken++;
                        if (m_taken == NP) m_phase = MP_WAIT;
                    end
                end
                MP_WAIT: begin
                    if (m_c == 2'b00) begin
                        m_phase = MP_IDLE;
                    end else if (frame_start) begin
                        for (int k = 0; k < NP; k++)
                            m_active[k] = m_clear ? '0 : m_shadow[k];
                        m_valid = !m_clear;
                        m_count = m_count + 1'b1;
                        m_phase = MP_ACK;
                    end
                end
                default: begin
                    if (m_c == 2'b00) m_phase = MP_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            for (int k = 0; k < NP; k++) m_exp[k*W +: W] = m_active[k];
            check("sw_sig", NW'(sw_sig), NW'(m_status(m_phase)));
            check("frame_valid", NW'(frame_valid), NW'(m_valid));
            check("frame_count", NW'(frame_count), NW'(m_count));
            check("frame_data", frame_data, m_exp);
        end
    end

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic set_words(input logic [W-1:0] base);
        for (int k = 0; k < NP; k++) port_data[k*W +: W] = base + W'(k);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " sw"}, NW'(sw_sig), '0);
        check({tag, " data"}, frame_data, '0);
        check({tag, " valid"}, NW'(frame_valid), '0);
        check({tag, " count"}, NW'(frame_count), '0);
    endtask

    int  r, abort_at, nwait;
    bit  abort, done;

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Reset then commit.
        @(negedge clk);
        set_words(32'hA500_0000);
        hw_sig = 2'b01;
        @(negedge clk);
        check("t1 sw ready", NW'(sw_sig), NW'(2'b00));
        @(negedge clk);
        check("t1 sw busy", NW'(sw_sig), NW'(2'b10));
        repeat (38) @(negedge clk);
        pulse_fs();
        check("t1 sw ack", NW'(sw_sig), NW'(2'b01));
        check("t1 word12", NW'(frame_data[12*W +: W]), NW'(32'hA500_000C));
        check("t1 valid", NW'(frame_valid), NW'(1'b1));
        check("t1 count", NW'(frame_count), NW'(16'd1));
        hw_sig = 2'b00;
        @(negedge clk);
        check("t1 sw hold", NW'(sw_sig), NW'(2'b01));
        @(negedge clk);
        check("t1 sw idle", NW'(sw_sig), NW'(2'b00));

        // Early frame_start during capture.
        hw_sig = 2'b01;
        repeat (6) @(negedge clk);
        pulse_fs();
        check("t2 early count", NW'(frame_count), NW'(16'd1));
        check("t2 early sw", NW'(sw_sig), NW'(2'b10));
        repeat (12) @(negedge clk);
        check("t2 wait count", NW'(frame_count), NW'(16'd1));
        pulse_fs();
        check("t2 swap count", NW'(frame_count), NW'(16'd2));
        check("t2 swap sw", NW'(sw_sig), NW'(2'b01));
        hw_sig = 2'b00;
        repeat (2) @(negedge clk);

        // Abort during WAIT_FRAME.
        set_words(32'hB600_0000);
        hw_sig = 2'b01;
        repeat (20) @(negedge clk);
        check("t3 busy", NW'(sw_sig), NW'(2'b10));
        hw_sig = 2'b00;
        repeat (2) @(negedge clk);
        check("t3 idle", NW'(sw_sig), NW'(2'b00));
        pulse_fs();
        @(negedge clk);
        check("t3 word12", NW'(frame_data[12*W +: W]), NW'(32'hA500_000C));
        check("t3 count", NW'(frame_count), NW'(16'd2));

        // Clear.
        hw_sig = 2'b10;
        repeat (3) @(negedge clk);
        check("t4 busy", NW'(sw_sig), NW'(2'b10));
        pulse_fs();
        check("t4 data", frame_data, '0);
        check("t4 valid", NW'(frame_valid), NW'(1'b0));
        check("t4 count", NW'(frame_count), NW'(16'd3));
        check("t4 sw", NW'(sw_sig), NW'(2'b01));
        hw_sig = 2'b00;
        repeat (2) @(negedge clk);

        // Reserved command.
        hw_sig = 2'b11;
        repeat (8) @(negedge clk);
        check("t5 err", NW'(sw_sig), NW'(2'b11));
        check("t5 count", NW'(frame_count), NW'(16'd3));
        hw_sig = 2'b00;
        @(negedge clk);
        check("t5 err hold", NW'(sw_sig), NW'(2'b11));
        @(negedge clk);
        check("t5 idle", NW'(sw_sig), NW'(2'b00));

        // Random command traffic.
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < NP; k++) port_data[k*W +: W] = $urandom;
            r = $urandom_range(0, 9);
            hw_sig = (r < 6) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11);
            abort = ($urandom_range(0, 4) == 0);
            abort_at = $urandom_range(1, 20);
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk);
                frame_start = !frame_start && ($urandom_range(0, 5) == 0);
                if (c == 6 && $urandom_range(0, 3) == 0)
                    hw_sig = 2'($urandom_range(1, 3));
                if (abort && c == abort_at) done = 1'b1;
                else if (c > 2 && (sw_sig == 2'b01 || sw_sig == 2'b11))
                    done = 1'b1;
            end
            if (!done) begin
                vectors++;
                miscompares++;
                $display("FAIL random txn %0d: no ack within budget, sw %b",
                         n, sw_sig);
            end
            frame_start = 1'b0;
            hw_sig = 2'b00;
            nwait = $urandom_range(1, 3);
            repeat (nwait) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Counter wrap at all-ones.
        @(posedge clk);
        #2;
        force dut.cnt_q = 16'hFFFF;
        m_count = 16'hFFFF;
        @(posedge clk);
        #2;
        release dut.cnt_q;
        @(negedge clk);
        check("t6 preset", NW'(frame_count), NW'(16'hFFFF));
        set_words(32'hC700_0000);
        hw_sig = 2'b01;
        repeat (16) @(negedge clk);
        pulse_fs();
        check("t6 wrap", NW'(frame_count), NW'(16'd0));
        check("t6 word3", NW'(frame_data[3*W +: W]), NW'(32'hC700_0003));
        hw_sig = 2'b00;
        repeat (2) @(negedge clk);
        hw_sig = 2'b01;
        repeat (16) @(negedge clk);
        pulse_fs();
        check("t6 count1", NW'(frame_count), NW'(16'd1));
        hw_sig = 2'b00;
        repeat (2) @(negedge clk);

        // Async reset in the middle of a capture.
        set_words(32'hD800_0000);
        hw_sig = 2'b01;
        repeat (6) @(negedge clk);
        check("t7 busy", NW'(sw_sig), NW'(2'b10));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t7 async");
        hw_sig = 2'b00;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("t7 after");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
